// File: rtl/ov7670_pixel_tx.sv
// ov7670_pixel_tx: OV7670-style RGB565 parallel bus transmitter driven by a built-in pattern generator.
module ov7670_pixel_tx #(
  parameter int c_img_cols     = 80,
  parameter int c_img_rows     = 60,
  parameter int c_nb_line_pxls = 7,
  parameter int c_pclk_div     = 2,
  parameter int c_hblank       = 16,
  parameter int c_vsync_lines  = 3,
  parameter int c_vbp_lines    = 2,
  parameter int c_vfp_lines    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy
);
  localparam int LINE = 2 * c_img_cols + c_hblank;
  localparam int HW = $clog2(LINE);
  localparam int DW = c_pclk_div > 1 ? $clog2(c_pclk_div) : 1;
  localparam int RW = $clog2(c_img_rows + 1);
  localparam int CW = c_nb_line_pxls;
  localparam logic [2:0] IDLE = 3'd0, VSYNC = 3'd1, VBACK = 3'd2, ACT_LINE = 3'd3, HBLANK = 3'd4, VFRONT = 3'd5;
  localparam logic [DW-1:0] D_LAST = DW'(c_pclk_div - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(c_hblank - 1);
  localparam logic [CW-1:0] C_LAST = CW'(c_img_cols - 1);
  localparam logic [RW-1:0] R_LAST = RW'(c_img_rows - 1);
  localparam logic [7:0] VS_LAST = 8'(c_vsync_lines - 1);
  localparam logic [7:0] VB_LAST = 8'(c_vbp_lines - 1);
  localparam logic [7:0] VF_LAST = 8'(c_vfp_lines - 1);
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [2:0]    state;
  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [7:0]    lcnt;
  logic [CW-1:0] col, px_col;
  logic [RW-1:0] row, px_row;
  logic          ph;
  logic [1:0]    pat;
  logic [15:0]   solid, ce, px;
  logic [5:0]    re;
  logic [2:0]    bar;
  logic          tick, fall, line_end;
  assign busy = state != IDLE;
  // px is the pixel whose byte goes out at the next pclk fall
  always_comb begin
    tick = div == D_LAST;
    fall = tick && (pclk || state == IDLE);
    line_end = hcnt == H_LAST;
    px_col = state == ACT_LINE ? (ph ? col + 1'b1 : col) : '0;
    px_row = state == HBLANK ? row + 1'b1 : (state == ACT_LINE ? row : '0);
    ce = 16'(px_col);
    re = 6'(px_row);
    bar = 3'(ce / 16'(c_img_cols / 8));
    px = pat == 2'd0 ? BARS[bar] :
         pat == 2'd1 ? {ce[4:0], re, ce[4:0] ^ re[4:0]} : solid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div <= '0;
      pclk <= 1'b0;
      hcnt <= '0;
      lcnt <= '0;
      col <= '0;
      row <= '0;
      ph <= 1'b0;
      pat <= '0;
      solid <= '0;
      vsync <= 1'b0;
      href <= 1'b0;
      data <= '0;
      frame_done <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      frame_done <= 1'b0;
      if (tick) pclk <= state != IDLE && !pclk;
      if (fall) begin
        case (state)
          IDLE: if (en) begin
            state <= VSYNC;
            vsync <= 1'b1;
            pat <= pattern;
            solid <= solid_color;
            hcnt <= '0;
            lcnt <= '0;
          end
          VSYNC: begin
            hcnt <= line_end ? '0 : hcnt + 1'b1;
            if (line_end) lcnt <= lcnt == VS_LAST ? '0 : lcnt + 1'b1;
            if (line_end && lcnt == VS_LAST) begin
              state <= VBACK;
              vsync <= 1'b0;
            end
          end
          VBACK: begin
            hcnt <= line_end ? '0 : hcnt + 1'b1;
            if (line_end) lcnt <= lcnt == VB_LAST ? '0 : lcnt + 1'b1;
            if (line_end && lcnt == VB_LAST) begin
              state <= ACT_LINE;
              href <= 1'b1;
              data <= px[15:8];
              col <= '0;
              row <= '0;
              ph <= 1'b0;
            end
          end
          ACT_LINE: begin
            ph <= !ph;
            if (!ph) data <= px[7:0];
            else if (col == C_LAST) begin
              state <= HBLANK;
              href <= 1'b0;
              data <= '0;
              col <= '0;
              hcnt <= '0;
            end else begin
              col <= col + 1'b1;
              data <= px[15:8];
            end
          end
          HBLANK: begin
            hcnt <= hcnt == HB_LAST ? '0 : hcnt + 1'b1;
            if (hcnt == HB_LAST && row == R_LAST) begin
              state <= VFRONT;
              row <= '0;
              lcnt <= '0;
            end else if (hcnt == HB_LAST) begin
              state <= ACT_LINE;
              row <= row + 1'b1;
              href <= 1'b1;
              data <= px[15:8];
            end
          end
          VFRONT: begin
            hcnt <= line_end ? '0 : hcnt + 1'b1;
            if (line_end) lcnt <= lcnt == VF_LAST ? '0 : lcnt + 1'b1;
            if (line_end && lcnt == VF_LAST) begin
              frame_done <= 1'b1;
              state <= en ? VSYNC : IDLE;
              vsync <= en;
              pat <= en ? pattern : pat;
              solid <= en ? solid_color : solid;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ov7670_pixel_tx.sv
// tb_ov7670_pixel_tx: scoreboard bench with a capture-side monitor reassembling RGB565 pixels.
module tb_ov7670_pixel_tx;
  localparam int COLS = 80;
  localparam int ROWS = 12;
  localparam int NPX = COLS * ROWS;
  localparam int FRAME_CLK = 19 * 176 * 4;
  logic clk = 0, rst = 1, en = 0;
  logic [1:0] pattern = 2'd2;
  logic [15:0] solid_color = 16'hF800;
  logic pclk, vsync, href, frame_done, busy;
  logic [7:0] data;
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] fb [0:NPX-1];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  int wr_cnt, last_addr, m_col, m_row, lines, hcount, lowcnt, vs_cnt;
  logic ph, vs_prev, href_prev;
  logic [7:0] b0;
  logic [15:0] px;

  ov7670_pixel_tx #(.c_img_rows(ROWS)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .solid_color(solid_color),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int p, input logic [15:0] s, input int c, input int r);
    logic [15:0] cc, rr;
    cc = 16'(c);
    rr = 16'(r);
    if (p == 0) return bars[c / 10];
    if (p == 1) return {cc[4:0], rr[5:0], cc[4:0] ^ rr[4:0]};
    return s;
  endfunction

  task automatic push_frame(input int p, input logic [15:0] s);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_q.push_back(model(p, s, c, r));
  endtask

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      ph = 0; m_col = 0; m_row = 0; lines = 0; hcount = 0; lowcnt = 0;
      vs_cnt = 0; vs_prev = 0; href_prev = 0; wr_cnt = 0;
    end else begin
      if (vsync && !vs_prev) begin lines = 0; m_row = 0; m_col = 0; wr_cnt = 0; vs_cnt = 0; end
      if (vsync) vs_cnt++;
      if (!vsync && vs_prev) chk("vsync_len", vs_cnt, 528);
      if (href) begin
        if (!href_prev && lines > 0) chk("hblank_len", lowcnt, 16);
        if (!ph) b0 = data;
        else begin
          px = {b0, data};
          if (exp_q.size() == 0) chk("pixel_unexpected", px, 0) ;
          else chk("pixel", px, exp_q.pop_front());
          last_addr = m_row * COLS + m_col;
          if (last_addr < NPX) fb[last_addr] = px;
          wr_cnt++;
          m_col++;
        end
        ph = !ph;
        hcount++;
      end else begin
        if (href_prev) begin
          chk("line_len", hcount, 160);
          hcount = 0; lines++; m_row++; m_col = 0; lowcnt = 0;
        end
        lowcnt++;
      end
      vs_prev = vsync;
      href_prev = href;
    end
  end

  task automatic wait_fd();
    int n = 0;
    while (!frame_done && n < 20000) begin @(negedge clk); n++; end
    if (!frame_done) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int r, input int c);
    int n = 0;
    while (!(href && m_row == r && m_col == c) && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("position_timeout", 0, 1);
  endtask

  task automatic start_latency();
    int lat = 0;
    while (!vsync && lat < 20) begin @(negedge clk); lat++; end
    chk("start_latency_ok", int'(lat <= 5), 1);
  endtask

  task automatic check_reset_outs();
    chk("rst_pclk", pclk, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic check_frame_geom();
    chk("lines_per_frame", lines, ROWS);
    chk("we_count", wr_cnt, NPX);
    chk("last_addr", last_addr, NPX - 1);
  endtask

  initial begin
    int t1, bad;
    push_frame(2, 16'hF800);
    en = 1;
    repeat (5) @(negedge clk);
    check_reset_outs();
    rst = 0;
    start_latency();
    pattern = 2'd0;
    push_frame(0, 16'h0);
    @(negedge clk);
    wait_fd();
    t1 = cyc;
    check_frame_geom();
    chk("solid_px0", fb[0], 16'hF800);
    chk("solid_pxlast", fb[NPX-1], 16'hF800);
    pattern = 2'd1;
    push_frame(1, 16'h0);
    @(negedge clk);
    wait_fd();
    chk("frame_interval", cyc - t1, FRAME_CLK);
    t1 = cyc;
    check_frame_geom();
    chk("bar_px0", fb[0], 16'hFFFF);
    chk("bar_px9", fb[9], 16'hFFFF);
    chk("bar_px10", fb[10], 16'hFFE0);
    chk("bar_px19", fb[19], 16'hFFE0);
    chk("bar_px35", fb[35], 16'h07E0);
    chk("bar_px70", fb[70], 16'h0000);
    chk("bar_px79", fb[79], 16'h0000);
    @(negedge clk);
    wait_pos(8, 0);
    en = 0;
    pattern = 2'd2;
    solid_color = 16'h1234;
    wait_fd();
    chk("frame_interval_stop", cyc - t1, FRAME_CLK);
    check_frame_geom();
    chk("grad_c5_r3", fb[3*COLS+5], 16'h2866);
    chk("grad_c79_r11", fb[11*COLS+79], 16'h7964);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pclk || vsync || href || busy || data != 0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("queue_drained", exp_q.size(), 0);
    push_frame(2, 16'h1234);
    en = 1;
    start_latency();
    wait_pos(6, 40);
    rst = 1;
    @(negedge clk);
    check_reset_outs();
    exp_q.delete();
    pattern = 2'd0;
    push_frame(0, 16'h0);
    bad = 0;
    repeat (4) begin @(negedge clk); if (vsync || busy) bad++; end
    chk("rst_wins_en", bad, 0);
    rst = 0;
    start_latency();
    en = 0;
    @(negedge clk);
    wait_fd();
    check_frame_geom();
    chk("bar_after_rst", fb[75], 16'h0000);
    repeat (10) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_pclk", pclk, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
